// File: rtl/first_one_drain_sequencer.sv
// Purpose: latch a request vector and emit one first-one code per set bit, lowest index first.
// Latency: first beat is valid the cycle after the vector is accepted; done pulses the cycle after the last beat.
// Backpressure: out_ready low holds the current beat stable; req_ready is high only in IDLE, so no reload while draining.
module first_one_drain_sequencer #(
   parameter int WIDTH  = 4,
   parameter int CODE_W = 3,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [WIDTH-1:0]  req_vec,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CODE_W-1:0] out_code,
   output logic              out_last,
   output logic              done,
   output logic [CNT_W-1:0]  drop_cnt
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

   logic [0:0]       state;
   logic [WIDTH-1:0] pending;
   logic             req_fire;
   logic             out_fire;
   logic             vec_zero;
   logic             pend_onehot;

   // Lowest set bit index plus one; zero when nothing is set.
   function automatic logic [CODE_W-1:0] first_code(input logic [WIDTH-1:0] v);
      logic [CODE_W-1:0] c;
      c = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (v[i]) c = CODE_W'(i + 1);
      end
      return c;
   endfunction

   // Handshake qualifiers and output decode, all driven from registered state.
   always_comb begin
      req_ready   = (state == ST_IDLE) && rst_n;
      req_fire    = req_valid && req_ready;
      vec_zero    = (req_vec == '0);
      pend_onehot = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);
      out_valid   = (state == ST_DRAIN);
      out_code    = out_valid ? first_code(pending) : '0;
      out_last    = out_valid && pend_onehot;
      out_fire    = out_valid && out_ready;
   end

   // State and pending bits: flush beats handshakes, reset beats everything.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         pending <= '0;
      end else if (flush) begin
         state   <= ST_IDLE;
         pending <= '0;
      end else if (state == ST_IDLE) begin
         if (req_fire && !vec_zero) begin
            state   <= ST_DRAIN;
            pending <= req_vec;
         end
      end else if (out_fire) begin
         pending <= pending & (pending - WIDTH'(1));
         if (out_last) state <= ST_IDLE;
      end
   end

   // One-cycle completion pulse after the final beat is taken, suppressed by flush.
   always_ff @(posedge clk) begin
      if (!rst_n) done <= 1'b0;
      else        done <= !flush && out_fire && out_last;
   end

   // Saturating count of accepted all-zero vectors.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (!flush && req_fire && vec_zero && (drop_cnt != '1)) begin
         drop_cnt <= drop_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_first_one_drain_sequencer.sv
// Directed bench for first_one_drain_sequencer: inputs driven and outputs sampled 1ns after each rising edge.
module tb_first_one_drain_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_vec;
   logic       flush;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_code;
   logic       out_last;
   logic       done;
   logic [7:0] drop_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   first_one_drain_sequencer #(.WIDTH(4), .CODE_W(3), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_vec   (req_vec),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .out_last  (out_last),
      .done      (done),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected codes/last for 4'b1111 with out_ready pattern 1,0,1,0,1,0,1.
   logic       rdy_pat  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [2:0] code_exp [7] = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4};
   logic       last_exp [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_vec = 4'h0; flush = 1'b0; out_ready = 1'b0;
      tick(); tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_code",  out_code,  0);
      chk("rst_out_last",  out_last,  0);
      chk("rst_done",      done,      0);
      chk("rst_drop_cnt",  drop_cnt,  0);
      chk("rst_req_ready", req_ready, 0);
      rst_n = 1'b1;
      #1;
      chk("idle_req_ready", req_ready, 1);

      // 1: 1010 drains as codes 2 then 4
      req_valid = 1'b1; req_vec = 4'b1010; out_ready = 1'b1;
      tick();
      req_valid = 1'b0; req_vec = 4'b0001;   // must be ignored while draining
      chk("t1_valid0", out_valid, 1);
      chk("t1_code0",  out_code,  2);
      chk("t1_last0",  out_last,  0);
      chk("t1_rdy_busy", req_ready, 0);
      tick();
      chk("t1_code1", out_code, 4);
      chk("t1_last1", out_last, 1);
      chk("t1_done_early", done, 0);
      tick();
      chk("t1_valid_end", out_valid, 0);
      chk("t1_done",      done,      1);
      chk("t1_req_ready", req_ready, 1);
      tick();
      chk("t1_done_pulse", done, 0);

      // 2: 1111 with stalls
      req_valid = 1'b1; req_vec = 4'b1111;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         out_ready = rdy_pat[i];
         #1;
         chk($sformatf("t2_valid%0d", i), out_valid, 1);
         chk($sformatf("t2_code%0d", i),  out_code,  code_exp[i]);
         chk($sformatf("t2_last%0d", i),  out_last,  last_exp[i]);
         tick();
      end
      chk("t2_done", done, 1);
      chk("t2_valid_end", out_valid, 0);

      // 3: single-bit vector
      out_ready = 1'b1; req_valid = 1'b1; req_vec = 4'b1000;
      tick();
      req_valid = 1'b0;
      chk("t3_code", out_code, 4);
      chk("t3_last", out_last, 1);
      tick();
      chk("t3_done", done, 1);

      // 4: zero vectors counted and saturated
      req_valid = 1'b1; req_vec = 4'b0000;
      tick();
      chk("t4_valid", out_valid, 0);
      chk("t4_drop1", drop_cnt, 1);
      chk("t4_ready", req_ready, 1);
      for (int i = 0; i < 253; i++) tick();
      chk("t4_drop254", drop_cnt, 254);
      for (int i = 0; i < 46; i++) tick();
      chk("t4_drop_sat", drop_cnt, 255);
      chk("t4_valid_end", out_valid, 0);
      req_valid = 1'b0;

      // 5: flush mid-drain, then a fresh vector
      req_valid = 1'b1; req_vec = 4'b0111; out_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("t5_code0", out_code, 1);
      tick();
      chk("t5_code1", out_code, 2);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t5_flush_valid", out_valid, 0);
      chk("t5_flush_done",  done,      0);
      chk("t5_flush_ready", req_ready, 1);
      req_valid = 1'b1; req_vec = 4'b0100;
      tick();
      req_valid = 1'b0;
      chk("t5_code_new", out_code, 3);
      chk("t5_last_new", out_last, 1);
      tick();
      chk("t5_done", done, 1);
      chk("t5_valid_end", out_valid, 0);

      // 6: reset mid-drain of 1110
      req_valid = 1'b1; req_vec = 4'b1110;
      tick();
      req_valid = 1'b0;
      chk("t6_code0", out_code, 2);
      tick();
      chk("t6_code1", out_code, 3);
      rst_n = 1'b0;
      tick();
      chk("t6_rst_valid", out_valid, 0);
      chk("t6_rst_code",  out_code,  0);
      chk("t6_rst_last",  out_last,  0);
      chk("t6_rst_done",  done,      0);
      chk("t6_rst_drop",  drop_cnt,  0);
      chk("t6_rst_ready", req_ready, 0);
      rst_n = 1'b1;
      #1;
      chk("t6_rel_ready", req_ready, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("t6_no_residual%0d", i), out_valid, 0);
      end

      // flush in IDLE discards an accepted zero vector without counting it
      req_valid = 1'b1; req_vec = 4'b0000; flush = 1'b1;
      tick();
      chk("flush_idle_drop", drop_cnt, 0);
      flush = 1'b0;
      tick();
      req_valid = 1'b0;
      chk("idle_drop_after", drop_cnt, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
